// File: rtl/demux_1a4_if.sv
// Stream/frame bundle for the 1:4 byte demultiplexer.
// The master side feeds serialized bytes and observes the rebuilt frames;
// the slave side is the demultiplexer itself.
interface demux_1a4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             sof_in;
  logic [WIDTH-1:0] data_out0;
  logic [WIDTH-1:0] data_out1;
  logic [WIDTH-1:0] data_out2;
  logic [WIDTH-1:0] data_out3;
  logic             validout0;
  logic             validout1;
  logic             validout2;
  logic             validout3;
  logic             frame_done;
  logic             partial;
  logic [7:0]       frame_cnt;

  modport master (
    output data_in, valid_in, sof_in,
    input  data_out0, data_out1, data_out2, data_out3,
    input  validout0, validout1, validout2, validout3,
    input  frame_done, partial, frame_cnt
  );

  modport slave (
    input  data_in, valid_in, sof_in,
    output data_out0, data_out1, data_out2, data_out3,
    output validout0, validout1, validout2, validout3,
    output frame_done, partial, frame_cnt
  );
endinterface

// File: rtl/demux_1a4.sv
// 1:4 byte-stream demultiplexer. Collects serialized bytes (lane order
// 0,1,2,3) into staging registers and emits a whole 4-lane frame for one
// cycle when the lane-3 byte arrives. A start-of-frame byte seen mid-frame
// flushes the partially collected lanes as a partial frame and starts a
// new frame with itself as lane 0. All outputs are registered.
module demux_1a4 #(
  parameter int WIDTH = 8
) (
  input  logic         clk_4f,
  input  logic         reset,
  demux_1a4_if.slave   bus
);

  // Lane pointer doubles as the frame-assembly state.
  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_t;

  lane_t            ptr;
  lane_t            ptr_nxt;
  logic [WIDTH-1:0] stg     [3];
  logic [WIDTH-1:0] stg_nxt [3];
  logic [2:0]       fill;
  logic [2:0]       fill_nxt;

  logic [WIDTH-1:0] dout     [4];
  logic [WIDTH-1:0] dout_nxt [4];
  logic [3:0]       vld;
  logic [3:0]       vld_nxt;
  logic             done;
  logic             done_nxt;
  logic             part;
  logic             part_nxt;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;

  // Register all state and outputs; reset clears everything, including data.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      ptr  <= LANE0;
      fill <= 3'b000;
      for (int i = 0; i < 3; i++) stg[i] <= '0;
      for (int i = 0; i < 4; i++) dout[i] <= '0;
      vld  <= 4'b0000;
      done <= 1'b0;
      part <= 1'b0;
      cnt  <= 8'd0;
    end else begin
      ptr  <= ptr_nxt;
      fill <= fill_nxt;
      for (int i = 0; i < 3; i++) stg[i] <= stg_nxt[i];
      for (int i = 0; i < 4; i++) dout[i] <= dout_nxt[i];
      vld  <= vld_nxt;
      done <= done_nxt;
      part <= part_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Next-state and next-output decode: accept, complete or SOF flush.
  always_comb begin
    ptr_nxt  = ptr;
    fill_nxt = fill;
    for (int i = 0; i < 3; i++) stg_nxt[i] = stg[i];
    for (int i = 0; i < 4; i++) dout_nxt[i] = dout[i];
    vld_nxt  = 4'b0000;
    done_nxt = 1'b0;
    part_nxt = 1'b0;
    cnt_nxt  = cnt;

    if (bus.valid_in) begin
      if (bus.sof_in && (ptr != LANE0)) begin
        // Realign: flush whatever lanes are filled, zero the rest.
        for (int i = 0; i < 3; i++) begin
          dout_nxt[i] = fill[i] ? stg[i] : '0;
          vld_nxt[i]  = fill[i];
        end
        dout_nxt[3] = '0;
        vld_nxt[3]  = 1'b0;
        done_nxt    = 1'b1;
        part_nxt    = 1'b1;
        stg_nxt[0]  = bus.data_in;
        fill_nxt    = 3'b001;
        ptr_nxt     = LANE1;
      end else if (ptr == LANE3) begin
        // Lane-3 byte completes the frame; emit it together with stg0..2.
        for (int i = 0; i < 3; i++) dout_nxt[i] = stg[i];
        dout_nxt[3] = bus.data_in;
        vld_nxt     = 4'b1111;
        done_nxt    = 1'b1;
        cnt_nxt     = cnt + 8'd1;
        fill_nxt    = 3'b000;
        ptr_nxt     = LANE0;
      end else begin
        // Plain accept into the current lane (SOF at lane 0 lands here too).
        stg_nxt[ptr]  = bus.data_in;
        fill_nxt[ptr] = 1'b1;
        ptr_nxt       = lane_t'(ptr + 2'd1);
      end
    end
  end

  assign bus.data_out0  = dout[0];
  assign bus.data_out1  = dout[1];
  assign bus.data_out2  = dout[2];
  assign bus.data_out3  = dout[3];
  assign bus.validout0  = vld[0];
  assign bus.validout1  = vld[1];
  assign bus.validout2  = vld[2];
  assign bus.validout3  = vld[3];
  assign bus.frame_done = done;
  assign bus.partial    = part;
  assign bus.frame_cnt  = cnt;

endmodule

// File: tb/tb_demux_1a4.sv
// Testbench for demux_1a4: directed scenarios followed by random traffic,
// every cycle compared against a queue-based frame model.
module tb_demux_1a4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  demux_1a4_if #(.WIDTH(8)) dif ();

  demux_1a4 #(.WIDTH(8)) dut (
    .clk_4f (clk),
    .reset  (reset),
    .bus    (dif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: bytes collected so far in the current frame, plus
  // the expected registered outputs.
  logic [7:0] q[$];
  logic [7:0] m_data [4];
  logic [3:0] m_vld;
  logic       m_fd;
  logic       m_part;
  logic [7:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), advance the model,
  // then compare all outputs at the following negedge.
  task automatic cyc(input logic r, input logic v, input logic s, input logic [7:0] d);
    reset        = r;
    dif.valid_in = v;
    dif.sof_in   = s;
    dif.data_in  = d;
    if (r) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
      m_vld = 4'h0; m_fd = 1'b0; m_part = 1'b0; m_cnt = 8'h00;
    end else begin
      m_vld = 4'h0; m_fd = 1'b0; m_part = 1'b0;
      if (v) begin
        if (s && q.size() != 0) begin
          for (int i = 0; i < 4; i++) begin
            if (i < q.size()) begin
              m_data[i] = q[i]; m_vld[i] = 1'b1;
            end else begin
              m_data[i] = 8'h00;
            end
          end
          m_fd = 1'b1; m_part = 1'b1;
          q.delete();
          q.push_back(d);
        end else begin
          q.push_back(d);
          if (q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_data[i] = q[i];
            m_vld = 4'hF; m_fd = 1'b1;
            m_cnt = m_cnt + 8'd1;
            q.delete();
          end
        end
      end
    end
    @(negedge clk);
    chk("data", {dif.data_out3, dif.data_out2, dif.data_out1, dif.data_out0},
        {m_data[3], m_data[2], m_data[1], m_data[0]});
    chk("ctrl", {dif.validout3, dif.validout2, dif.validout1, dif.validout0, dif.frame_done, dif.partial},
        {m_vld, m_fd, m_part});
    chk("frame_cnt", {24'd0, dif.frame_cnt}, {24'd0, m_cnt});
  endtask

  task automatic byte_in(input logic [7:0] d, input logic s = 1'b0);
    cyc(1'b0, 1'b1, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    logic [7:0] tbl [4];
    logic [7:0] cnt_before;
    reset = 1'b1; dif.valid_in = 1'b0; dif.sof_in = 1'b0; dif.data_in = 8'h00;

    // Reset then stream
    cyc(1'b1, 1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset_cnt", {24'd0, dif.frame_cnt}, 32'd0);
    tbl = '{8'h0F, 8'h02, 8'h08, 8'h14};
    for (int i = 0; i < 4; i++) byte_in(tbl[i]);
    chk("first_data", {dif.data_out3, dif.data_out2, dif.data_out1, dif.data_out0}, 32'h1408020F);
    chk("first_cnt", {24'd0, dif.frame_cnt}, 32'd1);
    idle(1);
    chk("hold_data", {24'd0, dif.data_out3}, 32'h14);

    // Gaps inside a frame
    byte_in(8'h16); idle(3);
    byte_in(8'h19); idle(3);
    byte_in(8'hF5); byte_in(8'h1E);
    chk("gap_cnt", {24'd0, dif.frame_cnt}, 32'd2);

    // Realign mid-frame
    byte_in(8'hAA); byte_in(8'hBB);
    byte_in(8'hCC, 1'b1);
    chk("realign_part", {31'd0, dif.partial}, 32'd1);
    chk("realign_cnt", {24'd0, dif.frame_cnt}, 32'd2);
    byte_in(8'hDD); byte_in(8'hEE); byte_in(8'hFF);
    chk("realign_full", {dif.data_out3, dif.data_out2, dif.data_out1, dif.data_out0}, 32'hFFEEDDCC);

    // SOF at lane 3, SOF without valid mid-frame
    byte_in(8'h01); byte_in(8'h02); byte_in(8'h03);
    byte_in(8'h04, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'h77);
    byte_in(8'h05); byte_in(8'h06); byte_in(8'h07);
    chk("sof3_next", {dif.data_out3, dif.data_out2, dif.data_out1, dif.data_out0}, 32'h07060504);

    // Reset mid-frame, clean frame afterwards
    byte_in(8'h31); byte_in(8'h32);
    cyc(1'b1, 1'b1, 1'b0, 8'h33);
    for (int i = 0; i < 4; i++) byte_in(8'h40 + 8'(i));
    chk("post_rst_cnt", {24'd0, dif.frame_cnt}, 32'd1);

    // 256 complete frames: counter wraps back to the same value
    cnt_before = dif.frame_cnt;
    for (int f = 0; f < 256; f++)
      for (int i = 0; i < 4; i++) byte_in(8'($urandom));
    chk("wrap_cnt", {24'd0, dif.frame_cnt}, {24'd0, cnt_before});

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) == 0), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
